// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath strobes.
// Optional build macro MIPS_CTRL_MEM_STALL_EN holds MEM_READ/MEM_WRITE until memReady is high.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               memReady,
  output logic               registerDestination,
  output logic               aluSource,
  output logic               memoryToRegister,
  output logic               registerWrite,
  output logic               memoryWrite,
  output logic               memRead,
  output logic [2:0]         aluOpcode,
  output logic               pcWrite,
  output logic [1:0]         pcSource,
  output logic               instrWrite,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    WB_R      = 4'd3,
    EXEC_I    = 4'd4,
    WB_I      = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_READ  = 4'd7,
    WB_MEM    = 4'd8,
    MEM_WRITE = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    TRAP      = 4'd12
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [2:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       instr_write;
    logic       illegal;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_reg, state_next;
  logic [5:0] funct_reg, funct_next;
  ctrl_t      ctrl_reg;
  logic       mem_hold;

`ifdef MIPS_CTRL_MEM_STALL_EN
  assign mem_hold = ~memReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = memReady;
  assign mem_hold = 1'b0;
`endif

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    logic [2:0] op;
    op = 3'b010;
    case (f)
      6'b100010: op = 3'b110;
      6'b100100: op = 3'b000;
      6'b100101: op = 3'b001;
      6'b101010: op = 3'b111;
      default:   op = 3'b010;
    endcase
    return op;
  endfunction

  // Moore output table; the R-type ALU code comes from the funct latched in DECODE.
  function automatic ctrl_t outputs_of(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c        = '0;
    c.alu_op = 3'b010;
    case (s)
      FETCH: begin
        c.instr_write = 1'b1;
        c.pc_write    = 1'b1;
      end
      EXEC_R: c.alu_op = alu_of_funct(f);
      WB_R: begin
        c.alu_op    = alu_of_funct(f);
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      EXEC_I, MEM_ADDR: c.alu_src = 1'b1;
      WB_I: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      MEM_READ: begin
        c.alu_src  = 1'b1;
        c.mem_read = 1'b1;
      end
      WB_MEM: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      BRANCH: begin
        c.alu_op    = 3'b110;
        c.pc_source = 2'b01;
        c.branch    = 1'b1;
      end
      JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      TRAP:    c.illegal = 1'b1;
      default: c = c;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = FETCH;
    funct_next = funct_reg;
    case (state_reg)
      FETCH: state_next = DECODE;
      DECODE: begin
        funct_next = funct;
        case (opcode)
          OP_RTYPE:     state_next = EXEC_R;
          OP_ADDI:      state_next = EXEC_I;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP;
        endcase
      end
      EXEC_R:    state_next = funct_ok(funct_reg) ? WB_R : TRAP;
      EXEC_I:    state_next = WB_I;
      MEM_ADDR:  state_next = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_next = mem_hold ? MEM_READ : WB_MEM;
      MEM_WRITE: state_next = mem_hold ? MEM_WRITE : FETCH;
      TRAP:      state_next = TRAP;
      default:   state_next = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      funct_reg <= '0;
      ctrl_reg  <= outputs_of(FETCH, 6'b000000);
    end else begin
      state_reg <= state_next;
      funct_reg <= funct_next;
      ctrl_reg  <= outputs_of(state_next, funct_next);
    end
  end

  // Strobes are gated by reset so FETCH's write enables never show while reset is held.
  assign registerDestination = ctrl_reg.reg_dst;
  assign aluSource           = ctrl_reg.alu_src;
  assign memoryToRegister    = ctrl_reg.mem_to_reg;
  assign aluOpcode           = ctrl_reg.alu_op;
  assign pcSource            = ctrl_reg.pc_source;
  assign illegal             = ctrl_reg.illegal;
  assign registerWrite       = reset & ctrl_reg.reg_write;
  assign memoryWrite         = reset & ctrl_reg.mem_write;
  assign memRead             = reset & ctrl_reg.mem_read;
  assign instrWrite          = reset & ctrl_reg.instr_write;
  assign pcWrite             = reset & (ctrl_reg.pc_write | (ctrl_reg.branch & zero));
  assign state               = STATE_W'(state_reg);

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore control FSM that sequences the MIPS datapath over multiple cycles per instruction.
- Decodes opcode/funct and drives the datapath control strobes: registerDestination, aluSource, memoryToRegister, registerWrite, memoryWrite, aluOpcode.
- Adds PC, IR and memory-read control on top of those strobes.
- Sits beside the datapath and replaces testbench-driven control.

Parameters:
- STATE_W, 4, width of state register and state debug port.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  input  6  instruction[31:26], valid from IR in DECODE and later.
- funct  input  6  instruction[5:0].
- zero  input  1  ALU zero flag.
- memReady  input  1  data-memory ready; used only with the optional feature.
- registerDestination  output  1  0 = rt[20:16], 1 = rd[15:11].
- aluSource  output  1  0 = register B, 1 = sign-extended immediate.
- memoryToRegister  output  1  0 = ALU result, 1 = memory data.
- registerWrite  output  1  register-file write strobe.
- memoryWrite  output  1  data-memory write strobe.
- memRead  output  1  data-memory read enable.
- aluOpcode  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pcWrite  output  1  PC load enable.
- pcSource  output  2  00 PC+4, 01 branch target, 10 jump target.
- instrWrite  output  1  IR load enable.
- illegal  output  1  sticky illegal-opcode flag.
- state  output  STATE_W  current state, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, EXEC_I=4, WB_I=5, MEM_ADDR=6, MEM_READ=7, WB_MEM=8, MEM_WRITE=9, BRANCH=10, JUMP=11, TRAP=12. Codes 13-15 go to FETCH.
- Reset (reset=0, async): state=FETCH, illegal=0, latched funct=0.
  - While reset is low, every strobe (pcWrite, instrWrite, registerWrite, memoryWrite, memRead) is forced to 0.
  - While reset is low, all other outputs are 0, except aluOpcode=010.
  - Reset mid-instruction abandons the instruction; no partial write occurs after reset falls.
- Outputs: decoded from state only, except pcWrite in BRANCH. Any output not listed for a state is 0; aluOpcode defaults to 010.
- FETCH: instrWrite=1, pcWrite=1, pcSource=00. Next state DECODE.
- DECODE: latch funct; dispatch on opcode:
  - 000000 (R-type) -> EXEC_R
  - 001000 (addi) -> EXEC_I
  - 100011 (lw), 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> TRAP
- EXEC_R: aluSource=0; aluOpcode from latched funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> TRAP instead of WB_R.
- WB_R: EXEC_R ALU controls held, registerDestination=1, registerWrite=1. Next FETCH.
- EXEC_I: aluSource=1, aluOpcode=010. Next WB_I.
- WB_I: aluSource=1, registerDestination=0, registerWrite=1. Next FETCH.
- MEM_ADDR: aluSource=1, aluOpcode=010. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: aluSource=1, memRead=1. Next WB_MEM.
- WB_MEM: aluSource=1, memoryToRegister=1, registerDestination=0, registerWrite=1. Next FETCH.
- MEM_WRITE: aluSource=1, memoryWrite=1. Next FETCH.
- BRANCH: aluSource=0, aluOpcode=110, pcSource=01, pcWrite=zero (combinational). Next FETCH.
- JUMP: pcSource=10, pcWrite=1. Next FETCH.
- TRAP: illegal=1 (sticky); all strobes 0; stay in TRAP until reset.
- Latency, FETCH to FETCH: R/addi/sw 4 cycles; lw 5; beq/j 3.
- Exactly one of registerWrite/memoryWrite/pcWrite/instrWrite may be high in a cycle, except FETCH (instrWrite+pcWrite).

Optional Feature:
- Macro: MIPS_CTRL_MEM_STALL_EN.
- Defined:
  - MEM_READ and MEM_WRITE hold their outputs and remain in state while memReady=0.
  - Exit occurs on the first rising edge with memReady=1.
  - memoryWrite stays high for all stalled cycles.
- Undefined: memReady is ignored; both states last exactly one cycle.

Test Plan:
- Reset: reset=0 then release, opcode=000000 funct=100000 -> state 0,1,2,3,0. registerWrite=1 only in cycle 4 with registerDestination=1, aluOpcode=010.
- lw: opcode=100011 -> 5 cycles. memRead=1 in state 7; memoryToRegister=1 and registerWrite=1 in state 8; memoryWrite never 1.
- beq: opcode=000100 with zero=1 -> pcWrite=1, pcSource=01 in state 10. Repeat with zero=0 -> pcWrite=0. Back in FETCH after 3 cycles.
- Illegal: opcode=111111 -> TRAP, illegal=1 held for 20 cycles, no strobes. reset=0 clears to FETCH with illegal=0.
- Bad funct: R-type with funct=000111 -> EXEC_R then TRAP; registerWrite never asserted.
- With MIPS_CTRL_MEM_STALL_EN: sw with memReady=0 for 3 cycles -> memoryWrite high 4 cycles total, then FETCH. Asserting reset mid-stall forces memoryWrite=0 immediately.
